// File: rtl/ysyx_22050612_multicycle_alu.sv
// Handshaked EX-stage ALU: single-cycle integer ops plus iterative multiply and
// optional iterative unsigned divide (enabled by YSYX_22050612_ALU_DIV_EN).
module ysyx_22050612_multicycle_alu #(
    parameter int XLEN = 64,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      mode,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Z,
    output logic            illegal
);

    localparam logic [7:0] M_ADD  = 8'd0;
    localparam logic [7:0] M_SUB  = 8'd1;
    localparam logic [7:0] M_SLT  = 8'd2;
    localparam logic [7:0] M_SLTU = 8'd3;
    localparam logic [7:0] M_OR   = 8'd4;
    localparam logic [7:0] M_AND  = 8'd6;
    localparam logic [7:0] M_XOR  = 8'd7;
    localparam logic [7:0] M_SLL  = 8'd8;
    localparam logic [7:0] M_SRL  = 8'd9;
    localparam logic [7:0] M_SRA  = 8'd10;
    localparam logic [7:0] M_MUL  = 8'd16;
`ifdef YSYX_22050612_ALU_DIV_EN
    localparam logic [7:0] M_DIVU = 8'd20;
    localparam logic [7:0] M_REMU = 8'd21;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REMU = 2'd2;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [SHW:0]    cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] z_q, z_d;
    logic            illegal_q, illegal_d;
`ifdef YSYX_22050612_ALU_DIV_EN
    logic [1:0]      op_q, op_d;
    logic [1:0]      dec_op;
`endif

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] single_z;
    logic            single_ill;
    logic            is_multi;

    assign shamt = B[SHW-1:0];

    // Decode: single-cycle results are computed directly from the issue operands.
    always_comb begin
        single_z   = '0;
        single_ill = 1'b0;
        is_multi   = 1'b0;
`ifdef YSYX_22050612_ALU_DIV_EN
        dec_op     = OP_MUL;
`endif
        case (mode)
            M_ADD:  single_z = A + B;
            M_SUB:  single_z = A - B;
            M_SLT:  single_z = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            M_SLTU: single_z = {{(XLEN-1){1'b0}}, (A < B)};
            M_OR:   single_z = A | B;
            M_AND:  single_z = A & B;
            M_XOR:  single_z = A ^ B;
            M_SLL:  single_z = A << shamt;
            M_SRL:  single_z = A >> shamt;
            M_SRA:  single_z = $signed(A) >>> shamt;
            M_MUL:  is_multi = 1'b1;
`ifdef YSYX_22050612_ALU_DIV_EN
            M_DIVU, M_REMU: begin
                dec_op = (mode == M_DIVU) ? OP_DIVU : OP_REMU;
                // Division by zero short-circuits to the RISC-V defined results.
                if (B == '0) begin
                    single_z = (mode == M_DIVU) ? '1 : A;
                end else begin
                    is_multi = 1'b1;
                end
            end
`endif
            default: single_ill = 1'b1;
        endcase
    end

    logic [XLEN-1:0] iter_a, iter_b, iter_acc, iter_res;
`ifdef YSYX_22050612_ALU_DIV_EN
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;
    logic            q_bit;
`endif

    // One iteration. Multiply: acc += a when b LSB set, a<<=1, b>>=1.
    // Divide (restoring): acc is the partial remainder, a shifts dividend out
    // at the top and quotient bits in at the bottom.
    always_comb begin
        iter_acc = acc_q + (b_q[0] ? a_q : '0);
        iter_a   = a_q << 1;
        iter_b   = b_q >> 1;
        iter_res = iter_acc;
`ifdef YSYX_22050612_ALU_DIV_EN
        rem_sh   = {acc_q, a_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        q_bit    = ~rem_diff[XLEN];
        if (op_q != OP_MUL) begin
            iter_acc = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            iter_a   = {a_q[XLEN-2:0], q_bit};
            iter_b   = b_q;
            iter_res = (op_q == OP_DIVU) ? iter_a : iter_acc;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        z_d       = z_q;
        illegal_d = illegal_q;
`ifdef YSYX_22050612_ALU_DIV_EN
        op_d      = op_q;
`endif
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_multi) begin
                            a_d     = A;
                            b_d     = B;
                            acc_d   = '0;
                            cnt_d   = (SHW+1)'(XLEN);
`ifdef YSYX_22050612_ALU_DIV_EN
                            op_d    = dec_op;
`endif
                            state_d = S_BUSY;
                        end else begin
                            z_d       = single_z;
                            illegal_d = single_ill;
                            state_d   = S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    a_d   = iter_a;
                    b_d   = iter_b;
                    acc_d = iter_acc;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == (SHW+1)'(1)) begin
                        z_d       = iter_res;
                        illegal_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            z_q       <= '0;
            illegal_q <= 1'b0;
`ifdef YSYX_22050612_ALU_DIV_EN
            op_q      <= OP_MUL;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            z_q       <= z_d;
            illegal_q <= illegal_d;
`ifdef YSYX_22050612_ALU_DIV_EN
            op_q      <= op_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Z         = z_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ysyx_22050612_multicycle_alu.sv
// Scoreboard bench for ysyx_22050612_multicycle_alu (XLEN=64); expectations for
// modes 20/21 follow YSYX_22050612_ALU_DIV_EN.
module tb_ysyx_22050612_multicycle_alu;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      mode = 8'd0;
    logic [XLEN-1:0] A = '0;
    logic [XLEN-1:0] B = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] Z;
    logic            illegal;

    ysyx_22050612_multicycle_alu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] z;
        logic            ill;
        int              lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   acc_edge = 0;
    logic ov_prev  = 1'b0;
    logic [XLEN-1:0] last_z = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready && !flush) acc_edge = cyc + 1;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    if (!ov_prev) chk("latency", XLEN'(cyc - acc_edge), XLEN'(sb[0].lat));
                    chk("Z", Z, sb[0].z);
                    chk("illegal", {63'd0, illegal}, {63'd0, sb[0].ill});
                    if (out_ready) void'(sb.pop_front());
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic issue(input logic [7:0] m, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] z, input logic ill, input int lat, input int hold);
        exp_t e;
        bit   seen;
        e.z = z; e.ill = ill; e.lat = lat;
        sb.push_back(e);
        last_z = z;
        mode = m; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = out_valid;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            seen = out_valid;
        end
        if (!seen) begin
            chk("out_valid_timeout", 64'd0, 64'd1);
            sb.delete();
        end else begin
            chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
            repeat (hold) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("in_ready_after_take", {63'd0, in_ready}, 64'd1);
        end
    endtask

    initial begin
        bit saw_ov;
        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_Z", Z, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(8'd1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0, 2);
        issue(8'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 0, 0);
        issue(8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 0, 0);
        issue(8'd10, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b0, 0, 0);
        issue(8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd2, 1'b0, 0, 0);
        issue(8'd4, 64'hF0, 64'h0F, 64'hFF, 1'b0, 0, 0);
        issue(8'd6, 64'hFF00, 64'h0FF0, 64'h0F00, 1'b0, 0, 0);
        issue(8'd7, 64'hFF, 64'h0F, 64'hF0, 1'b0, 0, 0);
        issue(8'd8, 64'd1, 64'h41, 64'd2, 1'b0, 0, 0);
        issue(8'd8, 64'd1, 64'h40, 64'd1, 1'b0, 0, 0);
        issue(8'd9, 64'h8000_0000_0000_0000, 64'h3F, 64'd1, 1'b0, 0, 0);
        issue(8'd5, 64'd9, 64'd9, 64'd0, 1'b1, 0, 0);
        issue(8'd16, 64'h1_0000_0003, 64'h1_0000_0005, 64'h0000_0008_0000_000F, 1'b0, 64, 5);
`ifdef YSYX_22050612_ALU_DIV_EN
        issue(8'd20, 64'd100, 64'd7, 64'd14, 1'b0, 64, 0);
        issue(8'd21, 64'd100, 64'd7, 64'd2, 1'b0, 64, 0);
        issue(8'd20, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0);
        issue(8'd21, 64'd100, 64'd0, 64'd100, 1'b0, 0, 0);
`else
        issue(8'd20, 64'd100, 64'd7, 64'd0, 1'b1, 0, 0);
        issue(8'd21, 64'd100, 64'd7, 64'd0, 1'b1, 0, 0);
`endif

        // Flush part-way through a multiply: the result must never appear.
        mode = 8'd16; A = 64'd3; B = 64'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_Z_held", Z, last_z);
        saw_ov = 1'b0;
        repeat (70) begin @(posedge clk); #1; saw_ov |= out_valid; end
        chk("flush_no_out_valid", {63'd0, saw_ov}, 64'd0);

        // Asynchronous reset in the middle of a multiply.
        issue(8'd0, 64'd40, 64'd2, 64'd42, 1'b0, 0, 0);
        mode = 8'd16; A = 64'd7; B = 64'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_Z", Z, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(8'd0, 64'd2, 64'd3, 64'd5, 1'b0, 0, 0);

        // in_valid together with flush in IDLE: nothing is accepted.
        mode = 8'd0; A = 64'd1; B = 64'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_accept_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_accept_Z", Z, 64'd5);
        issue(8'd7, 64'hAAAA, 64'h5555, 64'hFFFF, 1'b0, 0, 0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", XLEN'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
